// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the
// cache controller. The arbiter uses slave; requesters/cache use master.
interface mem_arbiter_if;
   logic        i_rd;
   logic [15:0] i_addr;
   logic [15:0] i_rdata;
   logic        i_done;
   logic        i_stall;
   logic        i_err;
   logic        d_rd;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_done;
   logic        d_stall;
   logic        d_err;
   logic        d_hit;
   logic [15:0] c_addr;
   logic [15:0] c_data_in;
   logic        c_rd;
   logic        c_wr;
   logic [15:0] c_data_out;
   logic        c_done;
   logic        c_cachehit;
   logic        c_err;
   logic        busy;

   modport slave (
      input  i_rd, i_addr,
      output i_rdata, i_done, i_stall, i_err,
      input  d_rd, d_wr, d_addr, d_wdata,
      output d_rdata, d_done, d_stall, d_err, d_hit,
      output c_addr, c_data_in, c_rd, c_wr,
      input  c_data_out, c_done, c_cachehit, c_err,
      output busy
   );

   modport master (
      output i_rd, i_addr,
      input  i_rdata, i_done, i_stall, i_err,
      output d_rd, d_wr, d_addr, d_wdata,
      input  d_rdata, d_done, d_stall, d_err, d_hit,
      input  c_addr, c_data_in, c_rd, c_wr,
      output c_data_out, c_done, c_cachehit, c_err,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of the shared cache controller.
// One transaction at a time, alternating tie-break, watchdog abort.
module mem_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int CW      = $clog2(TIMEOUT)
) (
   input logic        clk,
   input logic        rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic          last_d;
   logic          c_rd_q;
   logic          c_wr_q;
   logic [15:0]   addr_q;
   logic [15:0]   wdata_q;
   logic [15:0]   rdata_q;
   logic          err_q;
   logic          hit_q;
   logic          done_i;
   logic          done_d;
   logic [CW-1:0] cnt;

   logic i_req;
   logic d_req;
   logic pick_d;

   assign i_req  = bus.i_rd;
   assign d_req  = bus.d_rd | bus.d_wr;
   // on a tie the port that did not win last time gets the grant
   assign pick_d = d_req & (~i_req | ~last_d);

   // arbitration FSM, downstream request latch and response capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         last_d  <= 1'b0;
         c_rd_q  <= 1'b0;
         c_wr_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         hit_q   <= 1'b0;
         done_i  <= 1'b0;
         done_d  <= 1'b0;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (i_req | d_req) begin
                  last_d <= pick_d;
                  if (pick_d) begin
                     addr_q  <= bus.d_addr;
                     wdata_q <= bus.d_wdata;
                     if (bus.d_rd & bus.d_wr) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        hit_q   <= 1'b0;
                        done_d  <= 1'b1;
                        state   <= RESP;
                     end else begin
                        c_rd_q <= bus.d_rd;
                        c_wr_q <= bus.d_wr;
                        state  <= BUSY_D;
                     end
                  end else begin
                     addr_q  <= bus.i_addr;
                     wdata_q <= '0;
                     c_rd_q  <= 1'b1;
                     c_wr_q  <= 1'b0;
                     state   <= BUSY_I;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (bus.c_done) begin
                  rdata_q <= c_wr_q ? wdata_q : bus.c_data_out;
                  err_q   <= bus.c_err;
                  hit_q   <= bus.c_cachehit;
                  c_rd_q  <= 1'b0;
                  c_wr_q  <= 1'b0;
                  done_i  <= (state == BUSY_I);
                  done_d  <= (state == BUSY_D);
                  state   <= RESP;
               end else if (cnt == LAST) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  hit_q   <= 1'b0;
                  c_rd_q  <= 1'b0;
                  c_wr_q  <= 1'b0;
                  done_i  <= (state == BUSY_I);
                  done_d  <= (state == BUSY_D);
                  state   <= RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               done_i <= 1'b0;
               done_d <= 1'b0;
               cnt    <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.c_rd      = c_rd_q;
   assign bus.c_wr      = c_wr_q;
   assign bus.c_addr    = (c_rd_q | c_wr_q) ? addr_q : '0;
   assign bus.c_data_in = (c_rd_q | c_wr_q) ? wdata_q : '0;

   assign bus.i_done  = done_i;
   assign bus.i_rdata = done_i ? rdata_q : '0;
   assign bus.i_err   = done_i & err_q;
   assign bus.i_stall = i_req & ~done_i;

   assign bus.d_done  = done_d;
   assign bus.d_rdata = done_d ? rdata_q : '0;
   assign bus.d_err   = done_d & err_q;
   assign bus.d_hit   = done_d & hit_q;
   assign bus.d_stall = d_req & ~done_d;

   assign bus.busy = (state != IDLE);

endmodule
